// File: rtl/fpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_pkg
// Description : Shared types and constants for the FDIV mantissa divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_div_pkg;

    localparam int DIV_FRACW = 24;
    localparam int DIV_EXTW  = 26;
    localparam int DIV_QW    = DIV_FRACW + DIV_EXTW;
    localparam int DIV_CNTW  = $clog2(DIV_QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : fpu_div_pkg
`default_nettype wire

// File: rtl/div_r2_step.sv
`default_nettype none
// ============================================================================
// Module      : div_r2_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder and subtracts
//               the divisor when it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module div_r2_step
    import fpu_div_pkg::*;
#(
    parameter int FRACW = DIV_FRACW
) (
    input  logic [FRACW:0]   i_r,
    input  logic             i_bit,
    input  logic [FRACW-1:0] i_divisor,
    output logic [FRACW:0]   o_r_next,
    output logic             o_qbit
);

    logic [FRACW:0] w_t;
    logic [FRACW:0] w_dvs;
    logic [FRACW:0] w_diff;

    // The remainder is always below the divisor, so its top bit is dropped
    // when shifting and the trial value still fits in FRACW+1 bits.
    always_comb begin
        w_t      = {i_r[FRACW-1:0], i_bit};
        w_dvs    = {1'b0, i_divisor};
        w_diff   = w_t - w_dvs;
        o_qbit   = (w_t >= w_dvs);
        o_r_next = o_qbit ? w_diff : w_t;
    end

endmodule : div_r2_step
`default_nettype wire

// File: rtl/div_r2_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_r2_seq
// Description : Sequential radix-2 restoring mantissa divider. One quotient
//               bit per clock, start/busy/done handshake, sideband tag
//               carried alongside the result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_r2_seq
    import fpu_div_pkg::*;
#(
    parameter int FRACW = DIV_FRACW,
    parameter int EXTW  = DIV_EXTW,
    parameter int TAGW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [FRACW-1:0]       fracta,
    input  logic [FRACW-1:0]       fractb,
    input  logic [TAGW-1:0]        tag_in,
    output logic                   busy,
    output logic                   done,
    output logic [FRACW+EXTW-1:0]  quo,
    output logic [FRACW-1:0]       rem,
    output logic                   rem_nz,
    output logic                   dbz,
    output logic [TAGW-1:0]        tag_out
);

    localparam int QW   = FRACW + EXTW;
    localparam int CNTW = $clog2(QW);
    localparam logic [CNTW-1:0] c_CNT_LOAD = CNTW'(QW - 1);

    div_state_t         r_state;
    logic [CNTW-1:0]    r_cnt;
    logic [QW-1:0]      r_dividend;
    logic [FRACW-1:0]   r_divisor;
    logic [FRACW:0]     r_rem;
    logic [QW-1:0]      r_quo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [TAGW-1:0]    r_tag;

    logic               w_accept;
    logic [FRACW:0]     w_r_next;
    logic               w_qbit;

    // A new operation may begin whenever no iteration is in flight.
    assign w_accept = start && (r_state != RUN);

    div_r2_step #(
        .FRACW      (FRACW)
    ) u_step (
        .i_r        (r_rem),
        .i_bit      (r_dividend[QW-1]),
        .i_divisor  (r_divisor),
        .o_r_next   (w_r_next),
        .o_qbit     (w_qbit)
    );

    // Control FSM, iteration datapath and result/tag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_dividend <= {fracta, {EXTW{1'b0}}};
                r_divisor  <= fractb;
                r_tag      <= tag_in;
                r_cnt      <= c_CNT_LOAD;
                r_rem      <= '0;
                if (fractb == '0) begin
                    // Divide by zero resolves immediately with a saturated quotient.
                    r_state <= DONE;
                    r_quo   <= '1;
                    r_dbz   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= RUN;
                    r_quo   <= '0;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        r_dividend <= r_dividend << 1;
                        r_rem      <= w_r_next;
                        r_quo      <= {r_quo[QW-2:0], w_qbit};
                        if (r_cnt == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign quo     = r_quo;
    assign rem     = r_rem[FRACW-1:0];
    assign rem_nz  = |r_rem[FRACW-1:0];
    assign dbz     = r_dbz;
    assign tag_out = r_tag;

endmodule : div_r2_seq
`default_nettype wire

// File: tb/tb_div_r2_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_r2_seq
// Description : Directed self-checking bench for div_r2_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_r2_seq;

    localparam int FRACW = 24;
    localparam int EXTW  = 26;
    localparam int QW    = 50;
    localparam int TAGW  = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic [FRACW-1:0]  fracta;
    logic [FRACW-1:0]  fractb;
    logic [TAGW-1:0]   tag_in;
    logic              busy;
    logic              done;
    logic [QW-1:0]     quo;
    logic [FRACW-1:0]  rem;
    logic              rem_nz;
    logic              dbz;
    logic [TAGW-1:0]   tag_out;

    int n_pass  = 0;
    int n_total = 0;

    div_r2_seq #(
        .FRACW   (FRACW),
        .EXTW    (EXTW),
        .TAGW    (TAGW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .fracta  (fracta),
        .fractb  (fractb),
        .tag_in  (tag_in),
        .busy    (busy),
        .done    (done),
        .quo     (quo),
        .rem     (rem),
        .rem_nz  (rem_nz),
        .dbz     (dbz),
        .tag_out (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one cycle; returns 1 ns after the accepting edge.
    task automatic do_start(input logic [FRACW-1:0] a, input logic [FRACW-1:0] b,
                            input logic [TAGW-1:0] t);
        start  = 1'b1;
        fracta = a;
        fractb = b;
        tag_in = t;
        step();
        start  = 1'b0;
    endtask

    // Polls done once per cycle; the first sample is cycle 1. Returns 0 on timeout.
    task automatic wait_done(output int cyc, output logic saw_busy);
        cyc      = 0;
        saw_busy = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (busy) saw_busy = 1'b1;
            if (done) begin
                cyc = k;
                break;
            end
            step();
        end
    endtask

    int   cyc;
    logic sb;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        fracta = '0;
        fractb = '0;
        tag_in = '0;
        repeat (3) step();

        check("rst_busy",   64'(busy),    64'd0);
        check("rst_done",   64'(done),    64'd0);
        check("rst_quo",    64'(quo),     64'd0);
        check("rst_rem",    64'(rem),     64'd0);
        check("rst_dbz",    64'(dbz),     64'd0);
        check("rst_tag",    64'(tag_out), 64'd0);
        reset = 1'b0;
        step();

        // 1.0 / 1.0
        do_start(24'h800000, 24'h800000, 16'h1234);
        check("t1_busy_c1", 64'(busy), 64'd1);
        wait_done(cyc, sb);
        check("t1_cycle",   64'(cyc),     64'd51);
        check("t1_quo",     64'(quo),     64'h0000004000000);
        check("t1_rem",     64'(rem),     64'd0);
        check("t1_rem_nz",  64'(rem_nz),  64'd0);
        check("t1_dbz",     64'(dbz),     64'd0);
        check("t1_tag",     64'(tag_out), 64'h1234);
        check("t1_busy_dn", 64'(busy),    64'd0);
        step();
        check("t1_done_lo", 64'(done),    64'd0);
        check("t1_hold_quo",64'(quo),     64'h0000004000000);
        check("t1_hold_tag",64'(tag_out), 64'h1234);

        // 1.0 / 1.5 : non-zero remainder
        do_start(24'h800000, 24'hC00000, 16'h00A5);
        wait_done(cyc, sb);
        check("t2_cycle",   64'(cyc),     64'd51);
        check("t2_quo",     64'(quo),     64'h00000002AAAAAA);
        check("t2_rem",     64'(rem),     64'h800000);
        check("t2_rem_nz",  64'(rem_nz),  64'd1);
        check("t2_dbz",     64'(dbz),     64'd0);

        // Divide by zero
        step();
        do_start(24'h800000, 24'h000000, 16'hBEEF);
        wait_done(cyc, sb);
        check("dz_cycle",   64'(cyc),     64'd1);
        check("dz_busy",    64'(sb),      64'd0);
        check("dz_quo",     64'(quo),     {14'd0, {50{1'b1}}});
        check("dz_rem",     64'(rem),     64'd0);
        check("dz_rem_nz",  64'(rem_nz),  64'd0);
        check("dz_dbz",     64'(dbz),     64'd1);
        check("dz_tag",     64'(tag_out), 64'hBEEF);
        step();
        check("dz_done_lo", 64'(done),    64'd0);
        check("dz_hold_dbz",64'(dbz),     64'd1);

        // Handshake: start during RUN is ignored; start in DONE is accepted
        do_start(24'hC00000, 24'h800000, 16'h1111);
        repeat (4) step();
        do_start(24'h800000, 24'hC00000, 16'h9999);
        wait_done(cyc, sb);
        check("hs_a_cycle", 64'(cyc + 5), 64'd51);
        check("hs_a_quo",   64'(quo),     64'h0000006000000);
        check("hs_a_rem",   64'(rem),     64'd0);
        check("hs_a_tag",   64'(tag_out), 64'h1111);
        do_start(24'h800000, 24'hC00000, 16'h2222);
        check("hs_b_busy",  64'(busy),    64'd1);
        check("hs_b_done",  64'(done),    64'd0);
        wait_done(cyc, sb);
        check("hs_b_cycle", 64'(cyc),     64'd51);
        check("hs_b_quo",   64'(quo),     64'h00000002AAAAAA);
        check("hs_b_rem",   64'(rem),     64'h800000);
        check("hs_b_tag",   64'(tag_out), 64'h2222);

        // Reset at cycle 20 of a run, then a fresh operation
        step();
        do_start(24'hC00000, 24'h800000, 16'h3333);
        repeat (19) step();
        check("mr_busy_pre",64'(busy),    64'd1);
        reset = 1'b1;
        step();
        check("mr_busy",    64'(busy),    64'd0);
        check("mr_done",    64'(done),    64'd0);
        check("mr_quo",     64'(quo),     64'd0);
        check("mr_rem",     64'(rem),     64'd0);
        check("mr_rem_nz",  64'(rem_nz),  64'd0);
        check("mr_dbz",     64'(dbz),     64'd0);
        check("mr_tag",     64'(tag_out), 64'd0);
        reset = 1'b0;
        repeat (40) step();
        check("mr_idle_done",64'(done),   64'd0);
        check("mr_idle_busy",64'(busy),   64'd0);
        do_start(24'hC00000, 24'h800000, 16'h4444);
        wait_done(cyc, sb);
        check("mr_new_cycle",64'(cyc),    64'd51);
        check("mr_new_quo", 64'(quo),     64'h0000006000000);
        check("mr_new_rem", 64'(rem),     64'd0);
        check("mr_new_tag", 64'(tag_out), 64'h4444);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_div_r2_seq
`default_nettype wire

// File: doc/div_r2_seq.md
# div_r2_seq

Sequential radix-2 restoring mantissa divider for the FDIV path. It sits directly downstream of the FMUL/FDIV pre-normalization stage and consumes its registered 24-bit hidden-bit-restored fractions. It produces a 50-bit quotient and a 24-bit remainder for the post-normalization/rounding stage, one quotient bit per clock. A start/busy/done handshake and a captured sideband tag keep the exponent, sign and flags of the pre-normalization stage aligned with the result.

## Interface
Parameters:
- FRACW, 24, fraction width including hidden bit (divisor width, remainder width)
- EXTW, 26, zero bits appended below the dividend fraction; quotient width QW = FRACW+EXTW = 50
- TAGW, 16, sideband width (exponent, sign and exception flags carried alongside)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- fracta  in  FRACW  dividend fraction, used as {fracta, EXTW'b0}
- fractb  in  FRACW  divisor fraction
- tag_in  in  TAGW  sideband captured with an accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse: result valid
- quo  out  QW  quotient
- rem  out  FRACW  final partial remainder
- rem_nz  out  1  |rem, sticky input for rounding
- dbz  out  1  divisor was zero
- tag_out  out  TAGW  tag_in of the operation that produced the result

## Operation
- States: IDLE, RUN, DONE.
- Accept rule: start=1 in IDLE or DONE. start in RUN is ignored; no queueing.
- On accept:
  - latch the dividend shift register {fracta, EXTW'b0}, the divisor and tag_in.
  - clear the partial remainder R (FRACW+1 bits) and quo.
  - load counter = QW-1.
  - If fractb==0, go to DONE with quo='1, rem='0, dbz=1. Otherwise go to RUN with dbz=0.
- RUN iteration, one per edge:
  - T = {R[FRACW-1:0], dividend MSB}, and shift the dividend left.
  - If T >= {1'b0, divisor}: R = T - divisor and qbit=1. Otherwise R = T and qbit=0.
  - quo = {quo[QW-2:0], qbit}.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE lasts exactly one cycle with done=1. Next state is RUN/DONE if start is accepted, else IDLE.
- Result hold: quo, rem, rem_nz, dbz and tag_out hold their values from DONE through IDLE until the next accept. They are not valid during RUN.
- Width rule: R is FRACW+1 bits and the subtraction is FRACW+1 bits. The final rem is R[FRACW-1:0], which is always < divisor.
- Reset, including mid-operation:
  - state goes to IDLE and the counter clears.
  - busy, done, quo, rem, rem_nz, dbz and tag_out all go to 0.
  - any in-flight operation is discarded.

## Timing
- Start sampled at edge E0. Iterations occur at edges E1..E50. done is high in the cycle after E50, i.e. 51 cycles after the start cycle.
- busy is high from the cycle after E0 through the cycle after E49; it is low in the DONE cycle.
- Divide-by-zero: done is high in the cycle immediately after the start cycle, and busy never asserts.
- Back-to-back: start in the DONE cycle is accepted. The previous result is overwritten at that edge, so the consumer must capture it during done.
- Throughput: one division per 51 cycles.

## Structure
- Shared package fpu_div_pkg holds:
  - state enum div_state_t {IDLE, RUN, DONE}
  - constants DIV_FRACW=24, DIV_EXTW=26, DIV_QW=50
  - counter width $clog2(DIV_QW)
- Optional sub-module div_r2_step is a purely combinational single iteration: (R, bit_in, divisor) → (R_next, qbit). It is instantiated once. The FSM, counter, shift registers and tag capture stay in div_r2_seq.

## Test plan
- 1.0/1.0: fracta=fractb=24'h800000 → done at cycle 51, quo=50'h0000004000000, rem=0, rem_nz=0, dbz=0.
- 1.5/1.0: fracta=24'hC00000, fractb=24'h800000 → quo=50'h0000006000000, rem=0.
- 1.0/1.5: fracta=24'h800000, fractb=24'hC00000 → quo=50'h00000002AAAAAA, rem=24'h800000, rem_nz=1.
- Divide-by-zero: fractb=0, tag_in=16'hBEEF → done at cycle 1, quo=all ones, rem=0, dbz=1, tag_out=16'hBEEF, busy never 1.
- Handshake: start during RUN with different operands is ignored (first result is unchanged). Start in the DONE cycle is accepted and its done arrives exactly 51 cycles later. tag_out tracks each operation.
- Reset asserted at cycle 20 of a run → next cycle all outputs 0 and state IDLE. A new start completes correctly 51 cycles later.
